// File: rtl/opti_fixed_pkg.sv
// Fixed-point constants shared by the product receive path: Q4.26 products in, Q2.13 results out.
package opti_fixed_pkg;

  localparam int W16  = 16;
  localparam int W32  = 32;
  localparam int FRAC = 13;

  localparam logic [W16-1:0]    Q213_MAX = 16'h7FFF;
  localparam logic [W16-1:0]    Q213_MIN = 16'h8000;
  localparam logic signed [W32:0] RND_HALF = 33'sd4096;

  typedef logic signed [W16-1:0] q213_t;
  typedef logic signed [W32-1:0] q426_t;

endpackage

// File: rtl/opti_sync_fifo.sv
// Small synchronous FIFO: power-of-two storage, wrapping pointers, occupancy and empty flag.
// Writes when full and reads when empty are ignored.
module opti_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic [AW:0]   o_level,
  output logic          o_empty
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_empty   = (r_level == '0);
  assign w_push    = i_wr_en & (r_level != LP_FULL);
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/opti_requant_rx.sv
// Receive stage for multiplier products: Q4.26 -> Q2.13 round/saturate, then buffer in a FIFO.
// Optional saturation statistics are built when SAT_CNT_EN is defined.
module opti_requant_rx
  import opti_fixed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W32-1:0] in_p,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W16-1:0] out_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW:0]    level,
  input  logic           sat_clr,
  output logic           sat_flag,
  output logic [W16-1:0] sat_cnt
);

  localparam logic [AW+1:0] LP_DEPTH = (AW+2)'(DEPTH);
  localparam int            RW       = W32 - FRAC + 1;

  logic           r_in_ready;
  logic           r_stage_valid;
  logic [W32-1:0] r_stage_p;

  logic           w_accept;
  logic           w_pop;
  logic           w_empty;
  logic [AW:0]    w_level;
  logic [AW+1:0]  w_total;
  logic [W16-1:0] w_fifo_y;

  logic signed [W32:0]  w_sum;
  logic signed [RW-1:0] w_r;
  logic [FRAC-1:0]      w_unused_frac;
  logic                 w_sat_hi;
  logic                 w_sat_lo;
  logic [W16-1:0]       w_y;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = ~w_empty & out_ready;

  // Stage plus FIFO occupancy after this edge; the stage slot is reserved so writes never overflow.
  assign w_total = {1'b0, w_level} + (AW+2)'(r_stage_valid) + (AW+2)'(w_accept)
                 - (AW+2)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready    <= 1'b0;
      r_stage_valid <= 1'b0;
      r_stage_p     <= '0;
    end else begin
      r_in_ready    <= (w_total < LP_DEPTH);
      r_stage_valid <= w_accept;
      if (w_accept) r_stage_p <= in_p;
    end
  end

  // 33-bit sum keeps the most positive product from wrapping; the slice is an arithmetic shift.
  assign w_sum         = $signed({r_stage_p[W32-1], r_stage_p}) + RND_HALF;
  assign w_r           = w_sum[W32:FRAC];
  assign w_unused_frac = w_sum[FRAC-1:0];
  assign w_sat_hi      = ~w_r[RW-1] & (|w_r[RW-2:W16-1]);
  assign w_sat_lo      =  w_r[RW-1] & ~(&w_r[RW-2:W16-1]);

  always_comb begin
    w_y = w_r[W16-1:0];
    if (w_sat_hi)      w_y = Q213_MAX;
    else if (w_sat_lo) w_y = Q213_MIN;
  end

  opti_sync_fifo #(
    .W     (W16),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (r_stage_valid),
    .i_wr_data (w_y),
    .i_rd_en   (out_ready),
    .o_rd_data (w_fifo_y),
    .o_level   (w_level),
    .o_empty   (w_empty)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = ~w_empty;
  assign out_y     = w_empty ? '0 : w_fifo_y;
  assign level     = w_level;

`ifdef SAT_CNT_EN
  logic           r_sat_flag;
  logic [W16-1:0] r_sat_cnt;
  logic           w_sat_wr;

  assign w_sat_wr = r_stage_valid & (w_sat_hi | w_sat_lo);

  // A clear wins over a saturated write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else if (sat_clr) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else if (w_sat_wr) begin
      r_sat_flag <= 1'b1;
      if (r_sat_cnt != 16'hFFFF) r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
  assign sat_cnt  = r_sat_cnt;
`else
  logic w_unused_sat_clr;
  assign w_unused_sat_clr = sat_clr;
  assign sat_flag         = 1'b0;
  assign sat_cnt          = '0;
`endif

endmodule
